turn_countdown_timer: RTL and testbench

Per-turn countdown timer for the game. It produces the 4-bit seconds value that drives the seven-segment display controller, and the display shows 10 as "A". It counts down from TURN_SECONDS to 0 at one step per second, using a clock prescaler. It can be started, paused and cleared, and it flags timeout to the game FSM with a one-cycle pulse.

---
 rtl/turn_countdown_timer.sv | 102 ++++++++++
 tb/tb_turn_countdown_timer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/turn_countdown_timer.sv
// Per-turn countdown timer: reloads to TURN_SECONDS on start and steps down once per second.
// It flags each decrement (tick), the final one (timeout) and the low-time warning window.
module turn_countdown_timer #(
  parameter int CYCLES_PER_SEC = 50_000_000,
  parameter int TURN_SECONDS   = 10,
  parameter int LOW_THRESHOLD  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] seconds,
  output logic       running,
  output logic       tick,
  output logic       timeout,
  output logic       low_time
);

  localparam int              PW       = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CYCLES_PER_SEC - 1);
  localparam logic [3:0]      RELOAD   = 4'(TURN_SECONDS);
  localparam logic [3:0]      LOW_LIM  = 4'(LOW_THRESHOLD);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    sec_q, sec_d;
  logic          tick_q, tick_d;
  logic          tmo_q, tmo_d;
  logic          count_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      sec_q   <= RELOAD;
      tick_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    sec_d    = sec_q;
    tick_d   = 1'b0;
    tmo_d    = 1'b0;
    count_en = 1'b0;
    if (clear) begin
      state_d = IDLE;
      sec_d   = RELOAD;
      pre_d   = '0;
    end else if (start) begin
      state_d = RUN;
      sec_d   = RELOAD;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        IDLE:    sec_d = RELOAD;
        RUN:     if (pause) state_d = PAUSED;
                 else       count_en = 1'b1;
        // The release cycle counts so a pause costs exactly as many cycles as it was held.
        PAUSED:  if (!pause) begin
                   state_d  = RUN;
                   count_en = 1'b1;
                 end
        EXPIRED: sec_d = '0;
        default: state_d = IDLE;
      endcase
      if (count_en) begin
        if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          tick_d = 1'b1;
          if (sec_q <= 4'd1) begin
            sec_d   = '0;
            tmo_d   = 1'b1;
            state_d = EXPIRED;
          end else begin
            sec_d = sec_q - 4'd1;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
    end
  end

  assign seconds  = sec_q;
  assign running  = (state_q == RUN);
  assign tick     = tick_q;
  assign timeout  = tmo_q;
  assign low_time = (state_q == RUN) && (sec_q <= LOW_LIM);

endmodule

// File: tb/tb_turn_countdown_timer.sv
// Directed bench for turn_countdown_timer (CYCLES_PER_SEC=4, TURN_SECONDS=10, LOW_THRESHOLD=3).
// Expected outputs are queued per step and popped after the following clock edge.
module tb_turn_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause, clear;
  logic [3:0] seconds;
  logic       running, tick, timeout, low_time;

  int n_assert = 0;
  int n_fail   = 0;
  int ticks    = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  turn_countdown_timer #(
    .CYCLES_PER_SEC(4),
    .TURN_SECONDS  (10),
    .LOW_THRESHOLD (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .seconds (seconds),
    .running (running),
    .tick    (tick),
    .timeout (timeout),
    .low_time(low_time)
  );

  always #5 clk = ~clk;

  task automatic expect_push(input string tag, input logic [3:0] s, input logic r,
                             input logic t, input logic to, input logic l);
    exp_t e;
    e.tag = tag;
    e.val = {s, r, t, to, l};
    sb.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t       e;
    logic [7:0] obs;
    e   = sb.pop_front();
    obs = {seconds, running, tick, timeout, low_time};
    n_assert++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed sec=%0d run=%b tick=%b tmo=%b low=%b, expected sec=%0d run=%b tick=%b tmo=%b low=%b",
             e.tag, obs[7:4], obs[3], obs[2], obs[1], obs[0],
             e.val[7:4], e.val[3], e.val[2], e.val[1], e.val[0]);
    end
  endtask

  task automatic check_now(input string tag, input logic [3:0] s, input logic r,
                           input logic t, input logic to, input logic l);
    expect_push(tag, s, r, t, to, l);
    compare_pop();
  endtask

  // Drive inputs for the current cycle, then check the outputs of the next one.
  task automatic step(input string tag, input logic s_i, input logic p_i, input logic c_i,
                      input logic [3:0] s, input logic r, input logic t,
                      input logic to, input logic l);
    start = s_i;
    pause = p_i;
    clear = c_i;
    expect_push(tag, s, r, t, to, l);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] es;
    logic       er, et, eto, el;

    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
    #2 rst = 1'b0;
    #1 check_now("reset", 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check_now("reset_held", 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step("idle_after_reset", 0, 1, 0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full run: start in cycle 0, seconds 10 at cycle 1, 9 at 5, 0 at 41.
    step("start", 1, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 41; k++) begin
      es  = 4'(10 - (k - 1) / 4);
      et  = (k >= 5) && ((k - 1) % 4 == 0);
      eto = (k == 41);
      er  = (k < 41);
      el  = er && (es <= 4'd3);
      step(eto ? "timeout" : (el ? "low_time" : "full_run"), 0, 0, 0, es, er, et, eto, el);
      if (tick) ticks++;
    end
    for (int k = 0; k < 3; k++)
      step("expired_hold", 0, 1, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_assert++;
    assert (ticks == 10) else begin
      n_fail++;
      $error("FAIL tick_count: observed %0d required 10", ticks);
    end

    // Start from EXPIRED, then pause during cycles 3..9.
    step("start_expired", 1, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("run_c2", 0, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("run_c3", 0, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 4; k <= 10; k++)
      step("paused", 0, 1, 0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("resume", 0, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("pause_delayed_dec", 0, 0, 0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 13; k <= 15; k++)
      step("run_9", 0, 0, 0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    // Cycle 15 holds the terminal prescaler count; pause arrives there.
    for (int k = 16; k <= 18; k++)
      step("pause_terminal", 0, 1, 0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    step("term_resume_dec", 0, 0, 0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 20; k <= 35; k++) begin
      es = 4'(8 - (k - 19) / 4);
      et = ((k - 19) % 4 == 0);
      step("count_to_4", 0, 0, 0, es, 1'b1, et, 1'b0, 1'b0);
    end

    // Restart at seconds=4: reload and prescaler restart from 0.
    step("restart", 1, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 37; k <= 39; k++)
      step("restart_run", 0, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("restart_first_dec", 0, 0, 0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);

    step("pause_before_clear", 0, 1, 0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    step("clear_paused", 0, 1, 1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle_pause_ignored", 0, 1, 0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("clear_and_start", 1, 0, 1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("stay_idle", 0, 0, 0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);

    // start with pause high: one RUN cycle, then PAUSED.
    step("start_pause", 1, 1, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("then_paused", 0, 1, 0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("unpause", 0, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("clear_run", 0, 0, 1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset mid-run at seconds=6, coincident with a tick.
    step("start2", 1, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 17; k++) begin
      es = 4'(10 - (k - 1) / 4);
      et = (k >= 5) && ((k - 1) % 4 == 0);
      step("run_to_6", 0, 0, 0, es, 1'b1, et, 1'b0, 1'b0);
    end
    #2 rst = 1'b0;
    #1 check_now("async_reset", 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_now("async_reset_held", 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step("post_reset_idle", 0, 0, 0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_reset_idle", 0, 1, 0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_reset_idle", 0, 0, 0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_reset_start", 1, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("post_reset_run", 0, 0, 0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
